// File: rtl/sqrt_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sqrt_arb_pkg                                               |
// | Description : Shared types and default constants for the sqrt arbiter.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package sqrt_arb_pkg;

    localparam int c_WIDTH_DEFAULT   = 16;
    localparam int c_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/sqrt_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sqrt_arbiter_if                                            |
// | Description : Requester-side and engine-side signals of the arbiter.     |
// |               slave = arbiter view, master = environment view.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface sqrt_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]            req;
    logic [N_REQ-1:0][WIDTH-1:0] val;
    logic [N_REQ-1:0]            done;
    logic [WIDTH-1:0]            res;
    logic                        err;
    logic                        busy;
    logic [IW-1:0]               gnt_id;
    logic [WIDTH-1:0]            sq_val;
    logic                        sq_rst;
    logic [WIDTH-1:0]            sq_out;
    logic                        sq_eop;

    modport slave (
        input  req, val, sq_out, sq_eop,
        output done, res, err, busy, gnt_id, sq_val, sq_rst
    );

    modport master (
        output req, val, sq_out, sq_eop,
        input  done, res, err, busy, gnt_id, sq_val, sq_rst
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                 |
// | Description : Combinational round-robin pick. Search begins one past     |
// |               i_ptr and wraps modulo N_REQ.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  wire [N_REQ-1:0] i_req,
    input  wire [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IW-1:0]    o_idx,
    output logic             o_any
);

    // First requester found after the pointer wins
    always_comb begin : p_pick
        int w_cand;
        w_cand = 0;
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_cand = (int'(i_ptr) + i) % N_REQ;
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_idx         = w_cand[IW-1:0];
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sqrt_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sqrt_arbiter                                               |
// | Description : Round-robin sharing of one square-root engine between      |
// |               N_REQ requesters. Optional watchdog on the engine when     |
// |               SQRT_ARB_TIMEOUT_EN is defined.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sqrt_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = c_WIDTH_DEFAULT,
    parameter int TIMEOUT_CYC = c_TIMEOUT_DEFAULT
) (
    input wire            clk,
    input wire            rst,
    sqrt_arbiter_if.slave bus
);

    localparam int IW = $clog2(N_REQ);

    arb_state_t       r_state, w_state_nxt;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_gnt_id;
    logic [N_REQ-1:0] r_gnt_oh;
    logic [WIDTH-1:0] r_sq_val;
    logic [WIDTH-1:0] r_res;
    logic             r_eop_q;
    logic             r_drop;
    logic             r_run;

    logic [N_REQ-1:0] w_gnt_oh;
    logic [IW-1:0]    w_win_idx;
    logic             w_any;
    logic             w_eop_rise;
    logic             w_tmo_hit;
    logic             w_err_flag;
    logic             w_done_act;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt_oh),
        .o_idx (w_win_idx),
        .o_any (w_any)
    );

    assign w_eop_rise = bus.sq_eop & ~r_eop_q;

`ifdef SQRT_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_err;

    assign w_tmo_hit  = (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign w_err_flag = r_err;

    // Watchdog: counts WAIT cycles, flags a timeout when no eop edge arrived
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_START: begin
                    r_tmo_cnt <= '0;
                    r_err     <= 1'b0;
                end
                ST_WAIT: begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (!w_eop_rise && w_tmo_hit)
                        r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end
`else
    assign w_tmo_hit  = 1'b0;
    assign w_err_flag = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any) w_state_nxt = ST_START;
            ST_START: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (w_eop_rise || w_tmo_hit) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: grant latch, operand hold, result capture, drop tracking.
    // The eop edge register tracks the live eop every cycle, so an eop that
    // is already high when START is entered never reads as a rising edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr    <= IW'(N_REQ - 1);
            r_gnt_id <= '0;
            r_gnt_oh <= '0;
            r_sq_val <= '0;
            r_res    <= '0;
            r_eop_q  <= 1'b0;
            r_drop   <= 1'b0;
            r_run    <= 1'b0;
        end else begin
            r_run   <= 1'b1;
            r_eop_q <= bus.sq_eop;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_ptr    <= w_win_idx;
                        r_gnt_id <= w_win_idx;
                        r_gnt_oh <= w_gnt_oh;
                        r_sq_val <= bus.val[w_win_idx];
                        r_drop   <= 1'b0;
                    end
                end
                ST_START: begin
                    r_res  <= '0;
                    r_drop <= ~bus.req[r_gnt_id];
                end
                ST_WAIT: begin
                    if (!bus.req[r_gnt_id])
                        r_drop <= 1'b1;
                    if (w_eop_rise)
                        r_res <= bus.sq_out;
                    else if (w_tmo_hit)
                        r_res <= '0;
                end
                default: ;
            endcase
        end
    end

    // A dropped request still finishes its engine run but is never reported
    assign w_done_act = (r_state == ST_DONE) & ~r_drop;

    assign bus.done   = w_done_act ? r_gnt_oh : '0;
    assign bus.res    = w_done_act ? r_res : '0;
    assign bus.err    = w_done_act & w_err_flag;
    assign bus.busy   = (r_state != ST_IDLE);
    assign bus.gnt_id = r_gnt_id;
    assign bus.sq_val = r_sq_val;
    // Engine held in reset during arbiter reset, pulsed in START, and
    // pulsed again in DONE after a watchdog expiry to recover the engine.
    assign bus.sq_rst = r_run & (r_state != ST_START)
                      & ~((r_state == ST_DONE) & w_err_flag);

endmodule
`default_nettype wire

// File: tb/tb_sqrt_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sqrt_arbiter                                            |
// | Description : Directed scoreboard bench for sqrt_arbiter with a          |
// |               behavioural sqrt engine. Watchdog case built only when     |
// |               SQRT_ARB_TIMEOUT_EN is defined.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_sqrt_arbiter;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int TMO = 8;

    typedef struct {
        int         idx;
        logic [W-1:0] res;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   n_start = 0;
    exp_t q[$];

    // engine model controls
    int         eng_lat   = 4;
    bit         eng_hang  = 1'b0;
    bit         eop_force = 1'b0;
    int         eng_cnt   = 0;
    logic       eng_eop   = 1'b0;
    logic [W-1:0] eng_op  = '0;
    logic [W-1:0] eng_out = '0;

    sqrt_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    sqrt_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] isqrt(input logic [W-1:0] x);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= int'(x)) r++;
        return W'(r);
    endfunction

    // Engine: loads on sq_rst low, raises eop eng_lat edges later
    always @(posedge clk) begin
        if (bus.sq_rst === 1'b0) begin
            eng_cnt <= eng_lat;
            eng_eop <= 1'b0;
            eng_op  <= bus.sq_val;
            eng_out <= 16'hDEAD;
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1 && !eng_hang) begin
                eng_eop <= 1'b1;
                eng_out <= isqrt(eng_op);
            end
        end
    end

    assign bus.sq_eop = eng_eop | eop_force;
    assign bus.sq_out = eng_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.sq_rst === 1'b0) n_start++;
        if ((|bus.done) === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=%b expected none (t=%0t)", bus.done, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_vec", 32'(bus.done), 32'(1 << e.idx));
                chk("gnt_id",   32'(bus.gnt_id), 32'(e.idx));
                chk("res",      32'(bus.res), 32'(e.res));
                chk("err",      32'(bus.err), 32'(e.err));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int i, input int bound);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (bus.done[i] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("done%0d_seen", i), 32'(ok), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},   32'(bus.busy),   32'd0);
        chk({tag, "_done"},   32'(bus.done),   32'd0);
        chk({tag, "_res"},    32'(bus.res),    32'd0);
        chk({tag, "_err"},    32'(bus.err),    32'd0);
        chk({tag, "_gnt_id"}, 32'(bus.gnt_id), 32'd0);
        chk({tag, "_sq_val"}, 32'(bus.sq_val), 32'd0);
        chk({tag, "_sq_rst"}, 32'(bus.sq_rst), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        int c0;
        int p0;
        bit ok;

        bus.req = '0;
        for (int i = 0; i < N; i++) bus.val[i] = '0;
        rst = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b1;
        tick(2);

        // single requester, sqrt(16)=4, done L+3 edges after drive
        eng_lat = 4;
        bus.val[0] = 16'd16;
        bus.req[0] = 1'b1;
        q.push_back('{idx: 0, res: 16'd4, err: 1'b0});
        c0 = cyc;
        p0 = n_start;
        tick(1);
        chk("single_sq_val", 32'(bus.sq_val), 32'd16);
        chk("single_busy",   32'(bus.busy),   32'd1);
        wait_done(0, 30);
        chk("single_latency", 32'(cyc - c0), 32'(eng_lat + 3));
        chk("single_start_pulses", 32'(n_start - p0), 32'd1);
        bus.req[0] = 1'b0;
        tick(3);

        // four held requests, round robin from index 0 after reset
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        bus.val[0] = 16'd0;
        bus.val[1] = 16'd1;
        bus.val[2] = 16'd15;
        bus.val[3] = 16'd400;
        q.push_back('{idx: 0, res: 16'd0,  err: 1'b0});
        q.push_back('{idx: 1, res: 16'd1,  err: 1'b0});
        q.push_back('{idx: 2, res: 16'd3,  err: 1'b0});
        q.push_back('{idx: 3, res: 16'd20, err: 1'b0});
        q.push_back('{idx: 0, res: 16'd0,  err: 1'b0});
        bus.req = 4'b1111;
        wait_done(0, 30);
        wait_done(1, 30);
        wait_done(2, 30);
        wait_done(3, 30);
        wait_done(0, 30);
        bus.req = '0;
        tick(3);

        // requester 2 drops in WAIT: silent completion, then normal service
        eng_lat = 8;
        bus.val[2] = 16'd49;
        bus.req[2] = 1'b1;
        tick(4);
        chk("drop_busy_in_wait", 32'(bus.busy), 32'd1);
        bus.req[2] = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drop_busy_fall", 32'(ok), 32'd1);
        tick(1);
        bus.val[1] = 16'd1;
        bus.val[3] = 16'd100;
        q.push_back('{idx: 3, res: 16'd10, err: 1'b0});
        q.push_back('{idx: 1, res: 16'd1,  err: 1'b0});
        bus.req[1] = 1'b1;
        bus.req[3] = 1'b1;
        wait_done(3, 30);
        bus.req[3] = 1'b0;
        wait_done(1, 30);
        bus.req[1] = 1'b0;
        tick(3);

        // reset during WAIT aborts; pointer restarts so 1 beats 3
        eng_lat = 10;
        bus.val[2] = 16'd64;
        bus.req[2] = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(1);
        check_reset_outputs("midrst");
        bus.req[2] = 1'b0;
        tick(2);
        rst = 1'b1;
        bus.val[1] = 16'd25;
        bus.val[3] = 16'd9;
        q.push_back('{idx: 1, res: 16'd5, err: 1'b0});
        q.push_back('{idx: 3, res: 16'd3, err: 1'b0});
        bus.req[1] = 1'b1;
        bus.req[3] = 1'b1;
        wait_done(1, 30);
        bus.req[1] = 1'b0;
        wait_done(3, 30);
        bus.req[3] = 1'b0;
        tick(3);

        // eop stuck high through START: only the later fresh edge completes
        eng_lat = 6;
        eop_force = 1'b1;
        tick(1);
        bus.val[0] = 16'd225;
        q.push_back('{idx: 0, res: 16'd15, err: 1'b0});
        bus.req[0] = 1'b1;
        tick(4);
        chk("stuck_eop_busy", 32'(bus.busy), 32'd1);
        eop_force = 1'b0;
        wait_done(0, 30);
        bus.req[0] = 1'b0;
        tick(3);

`ifdef SQRT_ARB_TIMEOUT_EN
        // engine never finishes: err after TMO WAIT cycles, engine reset
        eng_lat  = 4;
        eng_hang = 1'b1;
        bus.val[2] = 16'd81;
        q.push_back('{idx: 2, res: 16'd0, err: 1'b1});
        c0 = cyc;
        bus.req[2] = 1'b1;
        wait_done(2, 40);
        chk("tmo_latency", 32'(cyc - c0), 32'(TMO + 2));
        chk("tmo_sq_rst",  32'(bus.sq_rst), 32'd0);
        bus.req[2] = 1'b0;
        eng_hang = 1'b0;
        tick(3);
`endif

        tick(5);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sqrt_arbiter.md
SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter WIDTH, default 16: operand and result width.
REQ-003 Parameter TIMEOUT_CYC, default 64: watchdog limit in clk cycles; used only with SQRT_ARB_TIMEOUT_EN.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clk  in  1  sole clock, all logic on posedge.
REQ-006 rst  in  1  synchronous active-low reset.
REQ-007 req  in  N_REQ  per-requester request level.
REQ-008 val  in  N_REQ x WIDTH  per-requester operand; held stable while req high.
REQ-009 done  out  N_REQ  one-cycle pulse to the served requester.
REQ-010 res  out  WIDTH  result; valid only in the cycle done is high.
REQ-011 err  out  1  timeout flag, coincident with done; tied 0 without SQRT_ARB_TIMEOUT_EN.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 gnt_id  out  $clog2(N_REQ)  index of the current or last granted requester.
REQ-014 sq_val  out  WIDTH  operand to the shared sqrt engine.
REQ-015 sq_rst  out  1  engine active-low start/reset; a low pulse starts a computation.
REQ-016 sq_out  in  WIDTH  engine result.
REQ-017 sq_eop  in  1  engine end-of-operation; its rising edge marks completion.

Function
REQ-018 FSM states are IDLE, START, WAIT and DONE.
REQ-019 IDLE: if any req is high, latch the winner index and its val into sq_val, then go to START next cycle.
REQ-020 START: drive sq_rst=0 for exactly one cycle, clear the eop edge register, then go to WAIT.
REQ-021 WAIT: sq_rst=1; on an sq_eop rising edge (sq_eop & ~eop_q), capture sq_out and go to DONE.
REQ-022 DONE: pulse done[gnt_id] for one cycle with res=captured value, then return to IDLE.
REQ-023 Round-robin arbitration: search starts at last granted index+1, modulo N_REQ; after reset the pointer is N_REQ-1, so index 0 wins first.
REQ-024 Simultaneous requests are granted in round-robin order; no requester waits more than N_REQ-1 services.
REQ-025 Latency from req sampled in IDLE to done pulse is engine latency + 3 cycles.
REQ-026 If the granted req drops before DONE, the operation completes, no done is issued, the result is discarded, and the FSM goes to IDLE.
REQ-027 A requester whose req stays high after its done is re-arbitrated normally in the next IDLE, with no back-to-back priority.
REQ-028 An sq_eop already high in START is ignored; only a fresh rising edge in WAIT counts.
REQ-029 sq_val is held constant from IDLE exit until return to IDLE.

Reset
REQ-030 While rst=0: state=IDLE, sq_rst=0 (engine held in reset), done=0, res=0, err=0, busy=0, gnt_id=0, sq_val=0, pointer=N_REQ-1.
REQ-031 Reset asserted mid-operation aborts the operation at the next edge with no done pulse.

Configuration
REQ-032 With SQRT_ARB_TIMEOUT_EN defined, a counter runs in WAIT; on reaching TIMEOUT_CYC without an eop edge, the FSM goes to DONE with res=0 and err=1, and the engine is reset via sq_rst=0 for one cycle.
REQ-033 Without SQRT_ARB_TIMEOUT_EN: no counter, WAIT waits indefinitely, and err is constant 0.

Structure
REQ-034 Package sqrt_arb_pkg holds the state enum typedef, the default WIDTH constant and the default TIMEOUT_CYC constant.
REQ-035 Sub-module rr_arbiter is combinational: req vector plus pointer in, one-hot grant and index out; it is instantiated once.

Verification
REQ-036 Single req[0], val[0]=16 -> sq_val=16, one sq_rst low pulse, done[0] with res=4 at engine latency+3 cycles.
REQ-037 req[3:0]=1111 with vals 0,1,15,400, held high -> served in order 0,1,2,3 with res 0,1,3,20, then 0 again.
REQ-038 req[2] dropped during WAIT -> no done pulse, busy falls after eop, next request is served normally.
REQ-039 rst=0 asserted in WAIT -> all outputs at reset values at the next edge; a new req[1] after release is served first by index 0/1 priority order.
REQ-040 SQRT_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=8, engine never raises eop -> done[gnt_id] with err=1 and res=0 after 8 WAIT cycles.
REQ-041 sq_eop stuck high entering START -> no premature done; completion occurs only on the next rising edge.
